tick_scheduler: RTL and testbench
=================================

// Module: tick_scheduler
// PURPOSE
//  Sequences the free-running divided_clocks bus from clock_divider into per-consumer tick enables.
//  Each channel selects one tap, detects its rising edge and emits single-cycle ticks (free-run) or
//  counts N ticks then signals done (one-shot). Serves elevator floor-travel and door timers.
//  Consumers stay on the single system clock; no derived clocks.
// PARAMETERS
//  NUM_CH   4   number of independent tick channels
//  TAP_W    5   width of tap select (indexes divided_clocks[31:0])
//  CNT_W    8   width of one-shot tick count
// PORTS
//  clock           in   1            system clock; all logic on posedge
//  reset_n         in   1            asynchronous, active-low reset
//  divided_clocks  in   32           counter bus from clock_divider, synchronous to clock
//  cfg_valid       in   1            config write request
//  cfg_ready       out  1            config accepted when cfg_valid && cfg_ready
//  cfg_ch          in   $clog2(NUM_CH)  target channel
//  cfg_tap         in   TAP_W        tap index for channel
//  cfg_count       in   CNT_W        one-shot tick count
//  cfg_oneshot     in   1            1 = one-shot, 0 = free-run
//  start           in   NUM_CH       per-channel start pulse
//  cancel          in   NUM_CH       per-channel cancel pulse
//  tick            out  NUM_CH       single-cycle tick enable
//  done            out  NUM_CH       single-cycle one-shot completion
//  busy            out  NUM_CH       channel in RUN
// BEHAVIOUR
//  - Reset: tick=0, done=0, busy=0; all channels IDLE, tap=0, count=0, oneshot=0; edge history=0.
//  - cfg_ready = !busy[cfg_ch] (combinational). Accepted write updates tap/count/oneshot at next edge;
//    same edge loads edge history with divided_clocks[new tap] -> no spurious tick from tap change.
//  - Edge detect (every channel, every cycle, any state): prev <= divided_clocks[tap].
//    rise = divided_clocks[tap] && !prev. In RUN, tick registered: tick <= rise (1-cycle latency).
//  - States per channel: IDLE, RUN.
//    IDLE --start--> RUN; remaining <= count; busy=1 next cycle.
//    RUN free-run: tick on each rise; stays RUN until cancel.
//    RUN one-shot: each rise decrements remaining; rise with remaining==1 -> tick and done in the
//      same cycle, channel -> IDLE (busy=0 that cycle).
//    RUN --cancel--> IDLE next edge; no tick/done emitted for that edge's rise.
//  - count==0 one-shot: start -> done pulse next cycle, no tick, remains IDLE.
//  - start && cancel same cycle: cancel wins (channel IDLE).
//  - start while RUN: restart; remaining reloaded, pending rise that cycle not counted.
//  - Writes to a busy channel are never accepted (cfg_ready=0); no partial update.
//  - Channels fully independent; simultaneous events on different channels never interact.
//  - reset_n low mid-run: immediate return to reset values; no done emitted.
//  - divided_clocks needs no synchroniser (same clock domain).
// STRUCTURE
//  - Package tick_sched_pkg: ch_state_t enum {CH_IDLE, CH_RUN}; DIV_W=32 constant.
//  - Sub-module tick_channel (one channel: config regs, edge detect, FSM, down-counter),
//    generated NUM_CH times; top holds cfg decode and cfg_ready mux.
// TESTING (drive divided_clocks from a real clock_divider instance)
//  1 Reset: hold reset_n=0 3 cycles -> tick=0, done=0, busy=0, cfg_ready=1.
//  2 ch0 tap=0 free-run, start -> tick[0] high every 2nd cycle, 1 cycle wide; cancel -> no further ticks.
//  3 ch1 tap=2 one-shot count=3, start -> exactly 3 ticks 8 cycles apart; done[1] with 3rd tick; busy[1] drops.
//  4 ch2 count=0 one-shot, start -> done[2] next cycle, no tick; start+cancel same cycle on ch3 -> stays IDLE.
//  5 cfg write to busy ch1 -> cfg_ready=0, config unchanged; tap change 0->1 while divided_clocks[1]=1
//    -> no tick until next genuine rise.
//  6 Assert reset_n=0 mid one-shot (remaining=2) -> busy/tick/done 0 immediately, no done after release.

Source files
------------

// File: rtl/tick_sched_pkg.sv
// tick_sched_pkg: shared channel state type and divider bus width for the tick scheduler
package tick_sched_pkg;

    localparam int DIV_W = 32;

    typedef enum logic {CH_IDLE, CH_RUN} ch_state_t;

endpackage

// File: rtl/tick_channel.sv
// tick_channel: one tick channel -- config registers, tap edge detect, IDLE/RUN FSM and one-shot down-counter
module tick_channel
    import tick_sched_pkg::*;
#(
    parameter int TAP_W = 5,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [DIV_W-1:0] divided_clocks,
    input  logic             cfg_we,
    input  logic [TAP_W-1:0] cfg_tap,
    input  logic [CNT_W-1:0] cfg_count,
    input  logic             cfg_oneshot,
    input  logic             start,
    input  logic             cancel,
    output logic             tick,
    output logic             done,
    output logic             busy
);

    logic [TAP_W-1:0] tap;
    logic [CNT_W-1:0] count;
    logic             oneshot;
    logic             prev;
    logic             rise;
    ch_state_t        state, state_n;
    logic [CNT_W-1:0] remaining, remaining_n;
    logic             tick_n, done_n;

    assign rise = divided_clocks[tap] && !prev;
    assign busy = state == CH_RUN;

    // Config capture; a tap change reloads the edge history from the new tap so it cannot fake a rise
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tap     <= '0;
            count   <= '0;
            oneshot <= 1'b0;
            prev    <= 1'b0;
        end else if (cfg_we) begin
            tap     <= cfg_tap;
            count   <= cfg_count;
            oneshot <= cfg_oneshot;
            prev    <= divided_clocks[cfg_tap];
        end else begin
            prev    <= divided_clocks[tap];
        end
    end

    // Channel state, remaining count and registered tick/done outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= CH_IDLE;
            remaining <= '0;
            tick      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            remaining <= remaining_n;
            tick      <= tick_n;
            done      <= done_n;
        end
    end

    // Next state: cancel beats start, start beats a pending rise, rises only count while running
    always_comb begin
        state_n     = state;
        remaining_n = remaining;
        tick_n      = 1'b0;
        done_n      = 1'b0;
        if (cancel) begin
            state_n = CH_IDLE;
        end else if (start) begin
            if (oneshot && count == '0) begin
                state_n = CH_IDLE;
                done_n  = 1'b1;
            end else begin
                state_n     = CH_RUN;
                remaining_n = count;
            end
        end else if (state == CH_RUN && rise) begin
            tick_n = 1'b1;
            if (oneshot) begin
                remaining_n = remaining - 1'b1;
                if (remaining == CNT_W'(1)) begin
                    state_n = CH_IDLE;
                    done_n  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/tick_scheduler.sv
// tick_scheduler: turns the divided_clocks bus into per-channel tick/done enables on the system clock
module tick_scheduler
    import tick_sched_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int TAP_W  = 5,
    parameter int CNT_W  = 8
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [DIV_W-1:0]          divided_clocks,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
    input  logic [TAP_W-1:0]          cfg_tap,
    input  logic [CNT_W-1:0]          cfg_count,
    input  logic                      cfg_oneshot,
    input  logic [NUM_CH-1:0]         start,
    input  logic [NUM_CH-1:0]         cancel,
    output logic [NUM_CH-1:0]         tick,
    output logic [NUM_CH-1:0]         done,
    output logic [NUM_CH-1:0]         busy
);

    localparam int CH_W = $clog2(NUM_CH);

    assign cfg_ready = !busy[cfg_ch];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        tick_channel #(
            .TAP_W(TAP_W),
            .CNT_W(CNT_W)
        ) u_ch (
            .clock         (clock),
            .reset_n       (reset_n),
            .divided_clocks(divided_clocks),
            .cfg_we        (cfg_valid && cfg_ready && cfg_ch == CH_W'(i)),
            .cfg_tap       (cfg_tap),
            .cfg_count     (cfg_count),
            .cfg_oneshot   (cfg_oneshot),
            .start         (start[i]),
            .cancel        (cancel[i]),
            .tick          (tick[i]),
            .done          (done[i]),
            .busy          (busy[i])
        );
    end

endmodule

// File: tb/tb_tick_scheduler.sv
// tb_tick_scheduler: scoreboard bench for tick_scheduler driven by a free-running divider counter
module tb_tick_scheduler;
    import tick_sched_pkg::*;

    localparam int NUM_CH = 4;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic [DIV_W-1:0]  dc;
    logic              cfg_valid, cfg_ready, cfg_oneshot;
    logic [1:0]        cfg_ch;
    logic [4:0]        cfg_tap;
    logic [7:0]        cfg_count;
    logic [NUM_CH-1:0] start, cancel, tick, done, busy;

    int     checks = 0;
    int     errors = 0;
    longint exp_q[$];
    int     s;

    tick_scheduler dut (
        .clock(clock), .reset_n(reset_n), .divided_clocks(dc),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
        .cfg_tap(cfg_tap), .cfg_count(cfg_count), .cfg_oneshot(cfg_oneshot),
        .start(start), .cancel(cancel), .tick(tick), .done(done), .busy(busy)
    );

    always #5 clock = ~clock;

    // Stand-in for clock_divider: a free-running counter on the same clock
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) dc <= '0;
        else          dc <= dc + 1'b1;
    end

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic longint ev_key(input int d, input int c, input int k);
        return longint'(d) * 8 + longint'(c * 2 + k);
    endfunction

    function automatic bit rise_at(input int v, input int tap);
        return ((v >> tap) & 1) == 1 && (((v - 1) >> tap) & 1) == 0;
    endfunction

    // Expected tick/done events for a channel started at the edge sampling s
    task automatic expect_run(input int ch, input int tap, input int st, input int cnt, input bit os, input int stop);
        int got = 0;
        for (int v = st + 1; v < stop && (!os || got < cnt); v++) begin
            if (rise_at(v, tap)) begin
                got++;
                exp_q.push_back(ev_key(v + 1, ch, 0));
                if (os && got == cnt) exp_q.push_back(ev_key(v + 1, ch, 1));
            end
        end
        exp_q.sort();
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    task automatic cfg_write(input int ch, input int tap, input int cnt, input bit os);
        cfg_valid = 1'b1; cfg_ch = 2'(ch); cfg_tap = 5'(tap); cfg_count = 8'(cnt); cfg_oneshot = os;
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic pulse(input logic [NUM_CH-1:0] st_m, input logic [NUM_CH-1:0] ca_m);
        start = st_m; cancel = ca_m;
        step();
        start = '0; cancel = '0;
    endtask

    // Pop the scoreboard for every tick/done the DUT produces
    always @(negedge clock) begin
        if (reset_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                for (int k = 0; k < 2; k++) begin
                    if (k == 0 ? tick[c] : done[c]) begin
                        if (exp_q.size() == 0) check("unexpected_event", ev_key(int'(dc), c, k), -1);
                        else check("event", ev_key(int'(dc), c, k), exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        cfg_valid = 0; cfg_ch = 0; cfg_tap = 0; cfg_count = 0; cfg_oneshot = 0; start = 0; cancel = 0;
        repeat (3) step();
        check("rst_tick", tick, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", cfg_ready, 1);
        reset_n = 1'b1;
        step();
        // free-run on tap 0, then cancel
        cfg_write(0, 0, 0, 0);
        s = int'(dc);
        expect_run(0, 0, s, 0, 0, s + 10);
        pulse(4'b0001, 4'b0000);
        check("busy0_run", busy[0], 1);
        repeat (9) step();
        pulse(4'b0000, 4'b0001);
        repeat (6) step();
        check("busy0_cancel", busy[0], 0);
        // one-shot count 3 on tap 2, with a rejected write while busy
        cfg_write(1, 2, 3, 1);
        s = int'(dc);
        expect_run(1, 2, s, 3, 1, s + 1000);
        pulse(4'b0010, 4'b0000);
        check("busy1_run", busy[1], 1);
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_tap = 5'd0; cfg_count = 8'd1; cfg_oneshot = 1'b0;
        #1 check("ready_busy", cfg_ready, 0);
        step();
        cfg_valid = 1'b0; cfg_ch = 2'd0;
        #1 check("ready_idle", cfg_ready, 1);
        for (int i = 0; i < 60 && busy[1]; i++) step();
        check("busy1_drop", busy[1], 0);
        // one-shot with count 0 completes at once
        cfg_write(2, 0, 0, 1);
        s = int'(dc);
        exp_q.push_back(ev_key(s + 1, 2, 1));
        exp_q.sort();
        pulse(4'b0100, 4'b0000);
        check("done2_pulse", done[2], 1);
        check("busy2_idle", busy[2], 0);
        step();
        check("done2_single", done[2], 0);
        // start and cancel together: cancel wins
        pulse(4'b1000, 4'b1000);
        check("busy3_idle", busy[3], 0);
        repeat (4) step();
        // tap change 0->1 while bit 1 is high
        for (int i = 0; i < 8 && dc[1:0] != 2'b10; i++) step();
        cfg_write(0, 1, 2, 1);
        s = int'(dc);
        expect_run(0, 1, s, 2, 1, s + 1000);
        pulse(4'b0001, 4'b0000);
        for (int i = 0; i < 40 && busy[0]; i++) step();
        check("busy0_drop", busy[0], 0);
        step();
        check("pending", exp_q.size(), 0);
        // reset in the middle of a one-shot
        s = int'(dc);
        expect_run(1, 2, s, 3, 1, s + 1000);
        pulse(4'b0010, 4'b0000);
        for (int i = 0; i < 40 && !tick[1]; i++) step();
        check("first_tick1", tick[1], 1);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_tick", tick, 0);
        check("mid_rst_done", done, 0);
        exp_q.delete();
        repeat (3) step();
        reset_n = 1'b1;
        repeat (40) step();
        check("post_rst_busy", busy, 0);
        check("post_rst_ready", cfg_ready, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
